// File: rtl/cache_control_if.sv
// CPU request/response and physical-memory handshake between the cache controller
// and its environment. The master side is the CPU plus physical memory model.
interface cache_control_if;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_byte_enable;
  logic       mem_resp;
  logic       pmem_read;
  logic       pmem_write;
  logic       pmem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative L1 cache: hit service, dirty-victim
// writeback, line allocation, plus saturating hit/miss counters.
module cache_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_control_if.slave   bus,
  input  logic             cmp_tag0,
  input  logic             cmp_tag1,
  input  logic             valid0_out,
  input  logic             valid1_out,
  input  logic             dirty0_out,
  input  logic             dirty1_out,
  input  logic             lru_out,
  output logic             pmem_addr_sel,
  output logic             dataarr0_write,
  output logic             dataarr1_write,
  output logic             tag0_write,
  output logic             tag1_write,
  output logic             valid0_write,
  output logic             valid1_write,
  output logic             dirtyarr0_write,
  output logic             dirtyarr1_write,
  output logic             dirty_in,
  output logic             lru_write,
  output logic             lru_in,
  output logic             datawaymux_sel,
  output logic             datainmux_sel,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {StCheck, StWriteback, StAllocate} state_e;

  state_e           state_q, state_d;
  logic             victim_q, victim_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic req, hit, hit_way, victim_dirty, byte_write;

  assign req          = bus.mem_read | bus.mem_write;
  assign hit          = (cmp_tag0 & valid0_out) | (cmp_tag1 & valid1_out);
  assign hit_way      = cmp_tag1 & valid1_out;
  assign victim_dirty = lru_out ? (valid1_out & dirty1_out) : (valid0_out & dirty0_out);
  // A write with an empty byte mask completes without touching data or dirty state.
  assign byte_write   = bus.mem_write & (|bus.mem_byte_enable);

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // State, victim and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StCheck;
      victim_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state, victim latch and saturating counter updates.
  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      StCheck: begin
        if (req && hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else if (req) begin
          victim_d = lru_out;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d  = victim_dirty ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        // A request dropped during writeback skips the fill.
        if (bus.pmem_resp) state_d = req ? StAllocate : StCheck;
      end
      StAllocate: begin
        if (bus.pmem_resp) state_d = StCheck;
      end
      default: state_d = StCheck;
    endcase
  end

  // Datapath controls and handshakes; everything held low during reset.
  always_comb begin
    bus.mem_resp    = 1'b0;
    bus.pmem_read   = 1'b0;
    bus.pmem_write  = 1'b0;
    pmem_addr_sel   = 1'b0;
    dataarr0_write  = 1'b0;
    dataarr1_write  = 1'b0;
    tag0_write      = 1'b0;
    tag1_write      = 1'b0;
    valid0_write    = 1'b0;
    valid1_write    = 1'b0;
    dirtyarr0_write = 1'b0;
    dirtyarr1_write = 1'b0;
    dirty_in        = 1'b0;
    lru_write       = 1'b0;
    lru_in          = 1'b0;
    datawaymux_sel  = 1'b0;
    datainmux_sel   = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StCheck: begin
          if (req && hit) begin
            bus.mem_resp   = 1'b1;
            datawaymux_sel = hit_way;
            lru_write      = 1'b1;
            lru_in         = ~hit_way;
            if (byte_write) begin
              dataarr0_write  = ~hit_way;
              dataarr1_write  = hit_way;
              dirtyarr0_write = ~hit_way;
              dirtyarr1_write = hit_way;
              dirty_in        = 1'b1;
            end
          end
        end
        StWriteback: begin
          bus.pmem_write = 1'b1;
          pmem_addr_sel  = 1'b1;
          datawaymux_sel = victim_q;
        end
        StAllocate: begin
          bus.pmem_read = 1'b1;
          // Arrays commit only when the full line has arrived.
          if (bus.pmem_resp) begin
            dataarr0_write  = ~victim_q;
            dataarr1_write  = victim_q;
            tag0_write      = ~victim_q;
            tag1_write      = victim_q;
            valid0_write    = ~victim_q;
            valid1_write    = victim_q;
            dirtyarr0_write = ~victim_q;
            dirtyarr1_write = victim_q;
            datainmux_sel   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
